div32b_iter: RTL and testbench



---
 rtl/div32b_iter_if.sv | 23 ++
 rtl/div32b_iter.sv | 97 +++++++++
 tb/tb_div32b_iter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/div32b_iter_if.sv
// Handshake bundle for the iterative divider: operand request, result response, and flush.
interface div32b_iter_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_signed;
  logic             op_rem;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  modport master (
    output in_valid, op_a, op_b, op_signed, op_rem, kill, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op_a, op_b, op_signed, op_rem, kill, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/div32b_iter.sv
// Radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics, one quotient bit per cycle.
module div32b_iter #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  div32b_iter_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIXUP, S_DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, r_b, r_result;
  logic [WIDTH:0]   r_r;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q, r_neg_r, r_op_rem, r_out_valid;

  logic             w_accept, w_b_zero, w_ovf;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_rs, w_t;

  assign w_b_zero = (bus.op_b == '0);
  assign w_ovf    = bus.op_signed && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
  assign w_a_mag  = (bus.op_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign w_b_mag  = (bus.op_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

  // Shift in the next dividend bit, then trial-subtract; a borrow means restore.
  assign w_rs = {r_r[WIDTH-1:0], r_q[WIDTH-1]};
  assign w_t  = w_rs - {1'b0, r_b};

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: if (bus.in_valid && !bus.kill) begin
        w_accept    = 1'b1;
        w_state_nxt = (w_b_zero || w_ovf) ? S_DONE : S_DIV;
      end
      S_DIV:   if (r_cnt == '0) w_state_nxt = S_FIXUP;
      S_FIXUP: w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.kill) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q         <= '0;
      r_b         <= '0;
      r_r         <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_op_rem    <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_q      <= w_a_mag;
          r_b      <= w_b_mag;
          r_r      <= '0;
          r_cnt    <= CW'(WIDTH-1);
          r_neg_q  <= bus.op_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
          r_neg_r  <= bus.op_signed & bus.op_a[WIDTH-1];
          r_op_rem <= bus.op_rem;
          // Special cases skip the iteration and land their result directly.
          if (w_b_zero)  r_result <= bus.op_rem ? bus.op_a : '1;
          else if (w_ovf) r_result <= bus.op_rem ? '0 : MIN_NEG;
        end
        S_DIV: begin
          r_r   <= w_t[WIDTH] ? w_rs : w_t;
          r_q   <= {r_q[WIDTH-2:0], ~w_t[WIDTH]};
          r_cnt <= r_cnt - 1'b1;
        end
        S_FIXUP: if (!bus.kill) begin
          if (r_op_rem) r_result <= r_neg_r ? -r_r[WIDTH-1:0] : r_r[WIDTH-1:0];
          else          r_result <= r_neg_q ? -r_q : r_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
endmodule

// File: tb/tb_div32b_iter.sv
// Directed and small random checks of div32b_iter: values, latency, backpressure, kill, reset.
module tb_div32b_iter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  div32b_iter_if #(.WIDTH(32)) u_if ();

  div32b_iter #(.WIDTH(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Independent RISC-V reference for DIV/DIVU/REM/REMU.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic rem);
    if (b == 32'd0) return rem ? a : 32'hFFFFFFFF;
    if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) return rem ? 32'd0 : 32'h80000000;
      return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    end
    return rem ? a % b : a / b;
  endfunction

  task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s, input logic rem);
    @(negedge clk);
    u_if.in_valid  = 1'b1;
    u_if.op_a      = a;
    u_if.op_b      = b;
    u_if.op_signed = s;
    u_if.op_rem    = rem;
    @(posedge clk);
    #1;
    u_if.in_valid  = 1'b0;
    // Scramble operands to show they are sampled only at accept.
    u_if.op_a      = ~a;
    u_if.op_b      = ~b;
    u_if.op_signed = ~s;
    u_if.op_rem    = ~rem;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic rem, input logic [31:0] exp,
                        input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    chk({tag, ":in_ready"}, 32'(u_if.in_ready), 32'd1);
    accept(a, b, s, rem);
    lat = 1;
    while (!u_if.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ":lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ":res"}, u_if.result, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ":hold_res"}, u_if.result, exp);
      chk({tag, ":hold_rdy"}, 32'(u_if.in_ready), 32'd0);
    end
    u_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    u_if.out_ready = 1'b0;
    chk({tag, ":post_rdy"}, 32'(u_if.in_ready), 32'd1);
    chk({tag, ":post_vld"}, 32'(u_if.out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rexp;
    logic        rs, rr, seen;
    u_if.in_valid  = 1'b0;
    u_if.op_a      = '0;
    u_if.op_b      = '0;
    u_if.op_signed = 1'b0;
    u_if.op_rem    = 1'b0;
    u_if.kill      = 1'b0;
    u_if.out_ready = 1'b0;

    #2;
    chk("rst_in_ready", 32'(u_if.in_ready), 32'd1);
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_result", u_if.result, 32'd0);
    #20 rst = 1'b0;

    run_op("u_q",    32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 34, 0);
    run_op("u_r",    32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34, 0);
    run_op("u_max",  32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 32'hFFFFFFFF, 34, 0);
    run_op("s_q",    32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 32'hFFFFFFFD, 34, 0);
    run_op("s_r",    32'hFFFFFFF9, 32'd2, 1'b1, 1'b1, 32'hFFFFFFFF, 34, 0);
    run_op("s_q2",   32'd7, 32'hFFFFFFFE, 1'b1, 1'b0, 32'hFFFFFFFD, 34, 0);
    run_op("s_r2",   32'd7, 32'hFFFFFFFE, 1'b1, 1'b1, 32'd1, 34, 0);
    run_op("z_uq",   32'h12345678, 32'd0, 1'b0, 1'b0, 32'hFFFFFFFF, 1, 0);
    run_op("z_ur",   32'h12345678, 32'd0, 1'b0, 1'b1, 32'h12345678, 1, 0);
    run_op("z_sq",   32'h12345678, 32'd0, 1'b1, 1'b0, 32'hFFFFFFFF, 1, 0);
    run_op("z_sr",   32'h12345678, 32'd0, 1'b1, 1'b1, 32'h12345678, 1, 0);
    run_op("ov_sq",  32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, 1, 0);
    run_op("ov_sr",  32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, 32'd0, 1, 0);
    run_op("ov_uq",  32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0, 34, 0);
    run_op("ov_ur",  32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 34, 0);
    run_op("bp",     32'd1000, 32'd33, 1'b0, 1'b0, 32'd30, 34, 10);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 3 == 0) rb = -rb;
      rs = 1'($urandom_range(0, 1));
      rr = 1'($urandom_range(0, 1));
      rexp = ref_div(ra, rb, rs, rr);
      run_op("rnd", ra, rb, rs, rr, rexp, 34, 0);
    end

    // Kill in the middle of the iteration.
    accept(32'd500, 32'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1 u_if.kill = 1'b1;
    @(posedge clk);
    #1 u_if.kill = 1'b0;
    chk("kill_in_ready", 32'(u_if.in_ready), 32'd1);
    chk("kill_out_valid", 32'(u_if.out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (u_if.out_valid) seen = 1'b1;
    end
    chk("kill_no_valid", 32'(seen), 32'd0);
    run_op("post_kill", 32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 34, 0);

    // Kill coinciding with a request drops it.
    @(negedge clk);
    u_if.in_valid = 1'b1;
    u_if.kill     = 1'b1;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    u_if.kill     = 1'b0;
    chk("kill_drop_rdy", 32'(u_if.in_ready), 32'd1);

    // Asynchronous reset mid-divide.
    accept(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(u_if.in_ready), 32'd1);
    chk("arst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("arst_result", u_if.result, 32'd0);
    #2 rst = 1'b0;
    run_op("post_rst", 32'd100, 32'd7, 1'b0, 1'b1, 32'd2, 34, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
